// File: rtl/issueque_int_if.sv
// Dispatch, CDB snoop and issue-side bus of the integer issue queue.
// The slave modport is the queue; the master modport is its environment.
interface issueque_int_if #(
    parameter int TAGW  = 6,
    parameter int DATAW = 32,
    parameter int OPW   = 6
);
    logic             dispatch_en;
    logic [OPW-1:0]   dispatch_opcode;
    logic [TAGW-1:0]  dispatch_rstag;
    logic [DATAW-1:0] dispatch_rsdata;
    logic             dispatch_rsvalid;
    logic [TAGW-1:0]  dispatch_rttag;
    logic [DATAW-1:0] dispatch_rtdata;
    logic             dispatch_rtvalid;
    logic [TAGW-1:0]  dispatch_rdtag;
    logic             issueque_full;
    logic             cdb_valid;
    logic [TAGW-1:0]  cdb_tag;
    logic [DATAW-1:0] cdb_data;
    logic             issueint_ready;
    logic [OPW-1:0]   issueint_opcode;
    logic [DATAW-1:0] issueint_rsdata;
    logic [DATAW-1:0] issueint_rtdata;
    logic [TAGW-1:0]  issueint_rdtag;
    logic             issueint_equeueint_done;

    modport slave (
        input  dispatch_en, dispatch_opcode, dispatch_rstag, dispatch_rsdata,
               dispatch_rsvalid, dispatch_rttag, dispatch_rtdata, dispatch_rtvalid,
               dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, issueint_equeueint_done,
        output issueque_full, issueint_ready, issueint_opcode, issueint_rsdata,
               issueint_rtdata, issueint_rdtag
    );

    modport master (
        output dispatch_en, dispatch_opcode, dispatch_rstag, dispatch_rsdata,
               dispatch_rsvalid, dispatch_rttag, dispatch_rtdata, dispatch_rtvalid,
               dispatch_rdtag, cdb_valid, cdb_tag, cdb_data, issueint_equeueint_done,
        input  issueque_full, issueint_ready, issueint_opcode, issueint_rsdata,
               issueint_rtdata, issueint_rdtag
    );
endinterface

// File: rtl/issueque_int.sv
// Integer issue queue: age-ordered compacting storage, CDB wakeup and
// oldest-ready selection toward the issue stage.
module issueque_int #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6,
    parameter int DATAW = 32,
    parameter int OPW   = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    issueque_int_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic             vld;
        logic [OPW-1:0]   op;
        logic [TAGW-1:0]  rd;
        logic [TAGW-1:0]  rstag;
        logic [DATAW-1:0] rsdat;
        logic             rsv;
        logic [TAGW-1:0]  rttag;
        logic [DATAW-1:0] rtdat;
        logic             rtv;
    } ent_t;

    ent_t          ent_q [DEPTH];
    ent_t          ent_d [DEPTH];
    ent_t          ext   [DEPTH+1];
    ent_t          new_ent;
    ent_t          sel_e;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] sel_idx;
    logic          any_rdy;
    logic          full;
    logic          do_done;
    logic          do_disp;
    int            wr_idx;

    function automatic ent_t snoop(ent_t e, logic cv, logic [TAGW-1:0] ct,
                                   logic [DATAW-1:0] cd);
        ent_t r;
        r = e;
        if (cv && e.vld && !e.rsv && e.rstag == ct) begin
            r.rsv   = 1'b1;
            r.rsdat = cd;
        end
        if (cv && e.vld && !e.rtv && e.rttag == ct) begin
            r.rtv   = 1'b1;
            r.rtdat = cd;
        end
        return r;
    endfunction

    // Oldest ready entry wins; scanning downward leaves the lowest index.
    always_comb begin
        sel_idx = '0;
        any_rdy = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].vld && ent_q[i].rsv && ent_q[i].rtv) begin
                sel_idx = IW'(i);
                any_rdy = 1'b1;
            end
        end
    end

    assign sel_e               = ent_q[sel_idx];
    assign bus.issueint_ready  = any_rdy;
    assign bus.issueint_opcode = any_rdy ? sel_e.op    : '0;
    assign bus.issueint_rsdata = any_rdy ? sel_e.rsdat : '0;
    assign bus.issueint_rtdata = any_rdy ? sel_e.rtdat : '0;
    assign bus.issueint_rdtag  = any_rdy ? sel_e.rd    : '0;

    assign full              = (count_q == CW'(DEPTH));
    assign bus.issueque_full = full;
    assign do_done           = bus.issueint_equeueint_done && any_rdy;
    assign do_disp           = bus.dispatch_en && (!full || do_done);

    always_comb begin
        new_ent.vld   = 1'b1;
        new_ent.op    = bus.dispatch_opcode;
        new_ent.rd    = bus.dispatch_rdtag;
        new_ent.rstag = bus.dispatch_rstag;
        new_ent.rsdat = bus.dispatch_rsdata;
        new_ent.rsv   = bus.dispatch_rsvalid;
        new_ent.rttag = bus.dispatch_rttag;
        new_ent.rtdat = bus.dispatch_rtdata;
        new_ent.rtv   = bus.dispatch_rtvalid;
    end

    // Compaction: slots at or above the retired one take their younger
    // neighbour; the extra invalid slot feeds the top. Snoop follows the shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ext[i] = ent_q[i];
        ext[DEPTH] = '0;
        wr_idx = int'(count_q) - (do_done ? 1 : 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (do_done && i >= int'(sel_idx))
                ent_d[i] = snoop(ext[i+1], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            else
                ent_d[i] = snoop(ext[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            if (do_disp && i == wr_idx)
                ent_d[i] = snoop(new_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            if (flush)
                ent_d[i].vld = 1'b0;
        end
        count_d = flush ? '0 : count_q + CW'(do_disp) - CW'(do_done);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i].vld <= 1'b0;
        end else begin
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end
endmodule
